// File: rtl/dm_subword_ctrl_pkg.sv
// Shared encodings for the data-memory sub-word controller.
// Access sizes match the immediate-extension op encodings.
package dm_subword_ctrl_pkg;

    typedef enum logic [1:0] {
        SZ_WORD = 2'b00,
        SZ_HALF = 2'b01,
        SZ_BYTE = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        LD_WAIT = 2'b01,
        RMW     = 2'b10
    } state_e;

    function automatic logic misaligned(
        input logic [1:0] size,
        input logic [1:0] off
    );
        logic bad;
        unique case (size)
            SZ_WORD: bad = (off != 2'b00);
            SZ_HALF: bad = off[0];
            SZ_BYTE: bad = 1'b0;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dm_subword_ctrl_sw_lane_unit.sv
// Little-endian lane merge for stores and lane extract/extend for loads.
module sw_lane_unit
    import dm_subword_ctrl_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] new_data,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        sign,
    output logic [31:0] merged,
    output logic [31:0] extracted
);

    logic [31:0] mask;
    logic [31:0] lanes;
    logic [31:0] sh_b;
    logic [31:0] sh_h;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        mask  = 32'hFFFF_FFFF;
        lanes = new_data;
        unique case (size)
            SZ_HALF: begin
                mask  = 32'h0000_FFFF << {offset[1], 4'b0};
                lanes = {2{new_data[15:0]}};
            end
            SZ_BYTE: begin
                mask  = 32'h0000_00FF << {offset, 3'b0};
                lanes = {4{new_data[7:0]}};
            end
            default: ;
        endcase
        merged = (word & ~mask) | (lanes & mask);
    end

    assign sh_b   = word >> {offset, 3'b0};
    assign sh_h   = word >> {offset[1], 4'b0};
    assign byte_v = sh_b[7:0];
    assign half_v = sh_h[15:0];

    always_comb begin
        unique case (size)
            SZ_HALF: extracted = {{16{sign & half_v[15]}}, half_v};
            SZ_BYTE: extracted = {{24{sign & byte_v[7]}}, byte_v};
            default: extracted = word;
        endcase
    end

endmodule

// File: rtl/dm_subword_ctrl.sv
// Data-memory access controller: word stores in one cycle,
// sub-word stores by read-modify-write, loads with lane extension.
module dm_subword_ctrl
    import dm_subword_ctrl_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_sign,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic [31:0]       rdata,
    output logic              rdata_valid,
    output logic              err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    state_e            state;
    state_e            state_nx;
    logic [ADDR_W+1:0] addr_q;
    logic [1:0]        size_q;
    logic              sign_q;
    logic [31:0]       wdata_q;
    logic              accept;
    logic              bad;
    logic              word_st;
    logic [31:0]       merged;
    logic [31:0]       extracted;
    logic              unused_addr;

    assign unused_addr = ^req_addr[31:ADDR_W+2];

    // Gated by reset so every output drops the instant reset asserts.
    assign req_ready = reset && (state == IDLE);
    assign accept    = req_valid && req_ready;
    assign bad       = misaligned(req_size, req_addr[1:0]);
    assign word_st   = req_we && (req_size == SZ_WORD);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (accept && !bad && !word_st)
                    state_nx = req_we ? RMW : LD_WAIT;
            end
            LD_WAIT: state_nx = IDLE;
            RMW:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = 32'h0;
        mem_addr  = addr_q[ADDR_W+1:2];
        if (reset) begin
            unique case (state)
                IDLE: begin
                    mem_addr = req_addr[ADDR_W+1:2];
                    if (accept && !bad) begin
                        mem_en = 1'b1;
                        if (word_st) begin
                            mem_we    = 1'b1;
                            mem_wdata = req_wdata;
                        end
                    end
                end
                RMW: begin
                    mem_en    = 1'b1;
                    mem_we    = 1'b1;
                    mem_wdata = merged;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q  <= '0;
            size_q  <= 2'b00;
            sign_q  <= 1'b0;
            wdata_q <= 32'h0;
        end else if (accept) begin
            addr_q  <= req_addr[ADDR_W+1:0];
            size_q  <= req_size;
            sign_q  <= req_sign;
            wdata_q <= req_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata       <= 32'h0;
            rdata_valid <= 1'b0;
            err         <= 1'b0;
        end else begin
            rdata_valid <= (state == LD_WAIT);
            err         <= accept && bad;
            if (state == LD_WAIT) rdata <= extracted;
        end
    end

    sw_lane_unit u_lane (
        .word      (mem_rdata),
        .new_data  (wdata_q),
        .offset    (addr_q[1:0]),
        .size      (size_q),
        .sign      (sign_q),
        .merged    (merged),
        .extracted (extracted)
    );

endmodule

// File: tb/tb_dm_subword_ctrl.sv
// Directed bench for dm_subword_ctrl with a behavioural synchronous RAM.
module tb_dm_subword_ctrl;

    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_sign;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic [31:0]       rdata;
    logic              rdata_valid;
    logic              err;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    logic [31:0] ram [0:(1<<ADDR_W)-1];
    logic        preload;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (preload) begin
            ram[0] <= 32'h8899AABB;
            ram[1] <= 32'h11223344;
            ram[2] <= 32'h0;
            mem_rdata <= 32'h0;
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr];
        end
    end

    dm_subword_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_size    (req_size),
        .req_sign    (req_sign),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .err         (err),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [1:0] size,
                         input logic sign, input logic [31:0] addr,
                         input logic [31:0] wdata);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_size  = size;
        req_sign  = sign;
        req_addr  = addr;
        req_wdata = wdata;
        #1;
    endtask

    task automatic idle_bus();
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_size  = 2'b00;
        req_sign  = 1'b0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
    endtask

    task automatic do_load(input string tag, input logic [1:0] size,
                           input logic sign, input logic [31:0] addr,
                           input logic [31:0] exp);
        drive(1'b0, size, sign, addr, 32'h0);
        check({tag, "_t_en"}, {31'b0, mem_en}, 32'd1);
        @(negedge clk);
        idle_bus();
        #1;
        check({tag, "_t1_ready"}, {31'b0, req_ready}, 32'd0);
        check({tag, "_t1_rv"}, {31'b0, rdata_valid}, 32'd0);
        @(negedge clk);
        check({tag, "_t2_rv"}, {31'b0, rdata_valid}, 32'd1);
        check({tag, "_t2_data"}, rdata, exp);
        check({tag, "_t2_ready"}, {31'b0, req_ready}, 32'd1);
    endtask

    task automatic do_err(input string tag, input logic we,
                          input logic [1:0] size, input logic [31:0] addr);
        drive(we, size, 1'b0, addr, 32'hCAFEF00D);
        check({tag, "_t_en"}, {31'b0, mem_en}, 32'd0);
        @(negedge clk);
        idle_bus();
        #1;
        check({tag, "_t1_err"}, {31'b0, err}, 32'd1);
        check({tag, "_t1_en"}, {31'b0, mem_en}, 32'd0);
        check({tag, "_t1_rv"}, {31'b0, rdata_valid}, 32'd0);
        check({tag, "_t1_ready"}, {31'b0, req_ready}, 32'd1);
        @(negedge clk);
        check({tag, "_t2_err"}, {31'b0, err}, 32'd0);
    endtask

    initial begin
        reset   = 1'b0;
        preload = 1'b1;
        idle_bus();
        #1;
        check("rst_rdata", rdata, 32'h0);
        check("rst_rv", {31'b0, rdata_valid}, 32'd0);
        check("rst_err", {31'b0, err}, 32'd0);
        check("rst_mem", {mem_wdata[29:0], mem_en, mem_we}, 32'd0);
        repeat (2) @(negedge clk);
        preload = 1'b0;
        reset   = 1'b1;

        do_load("lb_s_1", 2'b10, 1'b1, 32'h1, 32'hFFFFFFAA);
        do_load("lh_u_2", 2'b01, 1'b0, 32'h2, 32'h00008899);
        do_load("lh_s_2", 2'b01, 1'b1, 32'h2, 32'hFFFF8899);
        do_load("lb_u_0", 2'b10, 1'b0, 32'h0, 32'h000000BB);

        // Sub-word store: read at T, merged write at T+1.
        drive(1'b1, 2'b10, 1'b0, 32'h6, 32'h000000EE);
        check("sb_t_en_we", {30'b0, mem_en, mem_we}, 32'd2);
        check("sb_t_addr", {22'b0, mem_addr}, 32'd1);
        @(negedge clk);
        idle_bus();
        #1;
        check("sb_t1_ready", {31'b0, req_ready}, 32'd0);
        check("sb_t1_en_we", {30'b0, mem_en, mem_we}, 32'd3);
        check("sb_t1_addr", {22'b0, mem_addr}, 32'd1);
        check("sb_t1_wdata", mem_wdata, 32'h11EE3344);
        @(negedge clk);
        check("sb_t2_ready", {31'b0, req_ready}, 32'd1);
        check("sb_ram1", ram[1], 32'h11EE3344);

        drive(1'b1, 2'b00, 1'b0, 32'h8, 32'hDEADBEEF);
        check("sw_t_en_we", {30'b0, mem_en, mem_we}, 32'd3);
        check("sw_t_wdata", mem_wdata, 32'hDEADBEEF);
        check("sw_t_ready", {31'b0, req_ready}, 32'd1);
        @(negedge clk);
        idle_bus();
        #1;
        check("sw_t1_ready", {31'b0, req_ready}, 32'd1);
        check("sw_ram2", ram[2], 32'hDEADBEEF);
        do_load("lw_8", 2'b00, 1'b0, 32'h8, 32'hDEADBEEF);

        do_err("e_lh3", 1'b0, 2'b01, 32'h3);
        do_err("e_sw2", 1'b1, 2'b00, 32'h2);
        do_err("e_rsvd", 1'b0, 2'b11, 32'h0);
        check("e_ram0", ram[0], 32'h8899AABB);
        check("e_ram1", ram[1], 32'h11EE3344);
        check("e_ram2", ram[2], 32'hDEADBEEF);
        check("e_rdata_hold", rdata, 32'hDEADBEEF);

        // Reset lands in the RMW cycle; the write must be dropped.
        drive(1'b1, 2'b10, 1'b0, 32'h4, 32'h00000055);
        @(negedge clk);
        idle_bus();
        reset = 1'b0;
        #1;
        check("rr_en_we", {30'b0, mem_en, mem_we}, 32'd0);
        check("rr_wdata", mem_wdata, 32'h0);
        check("rr_ready", {31'b0, req_ready}, 32'd0);
        check("rr_rdata", rdata, 32'h0);
        check("rr_rv_err", {30'b0, rdata_valid, err}, 32'd0);
        @(negedge clk);
        check("rr_ram1", ram[1], 32'h11EE3344);
        reset = 1'b1;
        do_load("rr_lw4", 2'b00, 1'b0, 32'h4, 32'h11EE3344);
        do_load("rr_lb_s7", 2'b10, 1'b1, 32'h7, 32'h00000011);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
